// File: rtl/gpu_ctrl_pkg.sv
// Shared types and encodings for the Filter-GPU multicycle control unit:
// FSM state enum, opcode constants and datapath mux select encodings.
package gpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXER   = 4'd2,
        EXEI   = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // Opcodes as delivered by the instruction register
    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_VMEM = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Writeback result select
    localparam logic [1:0] RES_ALUOUT   = 2'b00;
    localparam logic [1:0] RES_READDATA = 2'b01;
    localparam logic [1:0] RES_ALU      = 2'b10;

    // Immediate extension format
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // True for the vector load/store opcode, which iterates over lanes
    function automatic logic isVectorOp(input logic [1:0] op);
        return op == OP_VMEM;
    endfunction

endpackage

// File: rtl/mc_lane_counter.sv
// SIMD lane index for vector load/store. Cleared by reset or at the end of
// a vector instruction, incremented after each completed lane access.
module mc_lane_counter
    import gpu_ctrl_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [LANE_W-1:0] lane,
    output logic              isLast
);

    logic [LANE_W-1:0] laneReg;

    // Lane register: clear has priority so an aborted vector op restarts at lane 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            laneReg <= '0;
        end else if (inc) begin
            laneReg <= laneReg + LANE_W'(1);
        end
    end

    assign lane   = laneReg;
    assign isLast = (laneReg == LANE_W'(LANES - 1));

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main decoder for the Filter-GPU control unit. Sequences
// fetch/decode/execute/memory/writeback and iterates vector load/store
// over LANES lanes. Optional macro MC_MEM_WAIT_EN: when defined, memory
// states wait on mem_ready; when undefined, mem_ready is ignored and every
// memory state takes exactly one cycle.
module mc_main_fsm
    import gpu_ctrl_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              cond_pass,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              IRWrite,
    output logic              MemW,
    output logic              RegW,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic              ALUOp,
    output logic              Branch,
    output logic [LANE_W-1:0] lane,
    output logic              retire
);

    state_t            stateReg;
    logic              memReady;
    logic [LANE_W-1:0] laneCount;
    logic              laneLast;
    logic              laneDone;
    logic              continueVec;
    logic              laneInc;
    logic              laneClr;
    logic              unusedBits;

`ifdef MC_MEM_WAIT_EN
    assign memReady   = mem_ready;
    assign unusedBits = ^Funct[4:1];
`else
    // Memory always completes in one cycle; the port stays for compatibility
    assign memReady   = 1'b1;
    assign unusedBits = ^{Funct[4:1], mem_ready};
`endif

    // A lane access finishes on leaving MEMWB, or MEMWR once memory accepts the write
    assign laneDone    = (stateReg == MEMWB) || ((stateReg == MEMWR) && memReady);
    // Vector ops loop back to MEMADR until the last lane has been served
    assign continueVec = isVectorOp(Op) && !laneLast;
    assign laneInc     = !rst && laneDone && continueVec;
    assign laneClr     = !rst && laneDone && isVectorOp(Op) && laneLast;

    mc_lane_counter #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clear  (laneClr),
        .inc    (laneInc),
        .lane   (laneCount),
        .isLast (laneLast)
    );

    // State register and transitions; unencoded states fall back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= FETCH;
        end else begin
            case (stateReg)
                FETCH:  if (memReady) stateReg <= DECODE;
                DECODE: begin
                    if (!cond_pass) begin
                        stateReg <= FETCH;
                    end else begin
                        case (Op)
                            OP_DP:          stateReg <= Funct[5] ? EXEI : EXER;
                            OP_MEM,
                            OP_VMEM:        stateReg <= MEMADR;
                            default:        stateReg <= BRANCH;
                        endcase
                    end
                end
                EXER:   stateReg <= ALUWB;
                EXEI:   stateReg <= ALUWB;
                ALUWB:  stateReg <= FETCH;
                MEMADR: stateReg <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  if (memReady) stateReg <= MEMWB;
                MEMWB:  stateReg <= continueVec ? MEMADR : FETCH;
                MEMWR:  if (memReady) stateReg <= continueVec ? MEMADR : FETCH;
                BRANCH: stateReg <= FETCH;
                default: stateReg <= FETCH;
            endcase
        end
    end

    // Output decode from the state register; everything forced low during reset
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemW      = 1'b0;
        RegW      = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ImmSrc    = IMM_8;
        RegSrc    = 2'b00;
        ALUOp     = 1'b0;
        Branch    = 1'b0;
        retire    = 1'b0;
        lane      = '0;
        if (!rst) begin
            lane = laneCount;
            case (stateReg)
                FETCH: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = memReady;
                    PCWrite   = memReady;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    retire    = !cond_pass;
                end
                EXER: begin
                    ALUSrcB = SRCB_REG;
                    ALUOp   = 1'b1;
                end
                EXEI: begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_8;
                    ALUOp   = 1'b1;
                end
                ALUWB: begin
                    RegW      = 1'b1;
                    ResultSrc = RES_ALUOUT;
                    retire    = 1'b1;
                end
                MEMADR: begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_12;
                    RegSrc  = {~Funct[0], 1'b0};
                end
                MEMRD: begin
                    AdrSrc = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = RES_READDATA;
                    RegW      = 1'b1;
                    retire    = !continueVec;
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    RegSrc = 2'b10;
                    MemW   = 1'b1;
                    retire = memReady && !continueVec;
                end
                BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ImmSrc    = IMM_24;
                    ResultSrc = RES_ALU;
                    RegSrc    = 2'b01;
                    Branch    = 1'b1;
                    PCWrite   = 1'b1;
                    retire    = 1'b1;
                end
                default: begin
                    lane = laneCount;
                end
            endcase
        end
    end

endmodule
